axi4_lite_reg_slave: RTL and testbench
======================================

// Module: axi4_lite_reg_slave
// PURPOSE
//   AXI4-Lite responder (slave) exposing NUM_REGS 32-bit read/write control registers.
//   Sits at the end of the AXI4-Lite interconnect and terminates AW/W/B and AR/R.
//   Responses use axi4_lite_pkg::response_t; AxPROT is decoded via axi4_lite_pkg::access_t.
//   Register contents drive the datapath (e.g. BCH encoder/decoder configuration) via reg_q.
// PARAMETERS
//   ADDR_W       8             byte-address width; word index = addr[ADDR_W-1:2]
//   NUM_REGS     8             number of 32-bit registers (1..2**(ADDR_W-2))
//   RESET_VALUE  '0            [NUM_REGS*32-1:0] reset contents; reg i = bits [32*i+31:32*i]
//   PRIV_MASK    '0            [NUM_REGS-1:0]; bit i set = reg i requires privileged access
// PORTS
//   aclk     in   1            clock; all logic on rising edge
//   areset   in   1            synchronous reset, active-high
//   awaddr   in   ADDR_W       write address
//   awprot   in   3            write access_t
//   awvalid  in   1            / awready out 1   write-address handshake
//   wdata    in   32           write data
//   wstrb    in   4            byte strobes; wstrb[k] enables wdata[8k+7:8k]
//   wvalid   in   1            / wready  out 1   write-data handshake
//   bresp    out  2            write response_t
//   bvalid   out  1            / bready  in  1   write-response handshake
//   araddr   in   ADDR_W       read address
//   arprot   in   3            read access_t
//   arvalid  in   1            / arready out 1   read-address handshake
//   rdata    out  32           read data
//   rresp    out  2            read response_t
//   rvalid   out  1            / rready  in  1   read-data handshake
//   reg_q    out  NUM_REGS*32  current register contents
//   reg_wr   out  NUM_REGS     1-cycle pulse: reg i updated by a successful write (OKAY only)
// BEHAVIOUR
//   Reset (areset=1 at edge): regs<=RESET_VALUE; bvalid=rvalid=0; bresp=rresp=OKAY; rdata=0;
//     reg_wr=0; awready=wready=arready=0 while areset=1, 1 from first cycle after release.
//   Reset mid-transaction aborts it: pending B/R dropped, captured AW/W discarded.
//   Write FSM (WR_IDLE, WR_RESP): in WR_IDLE, AW and W captured independently and in any order;
//     awready=1 until AW captured, wready=1 until W captured, then each held 0.
//     Both captured (incl. same cycle) -> next edge: commit write, bvalid=1, -> WR_RESP.
//     WR_RESP: awready=wready=0; bvalid/bresp stable until bready=1; -> WR_IDLE next cycle.
//     Latency: bvalid asserted 1 cycle after the later of the AW/W handshakes.
//   Read FSM (RD_IDLE, RD_RESP): arready=1 in RD_IDLE; handshake -> next edge rdata/rresp
//     registered, rvalid=1, -> RD_RESP (arready=0); hold until rready=1 -> RD_IDLE.
//     Max throughput: one read per 2 cycles, one write per 2 cycles.
//   Decode (same for both channels, low 2 address bits ignored):
//     index >= NUM_REGS                           -> DECERR, no write, rdata=0
//     PRIV_MASK[index] & prot[0]==UNPRIVILEGED    -> SLVERR, no write, rdata=0
//     otherwise                                   -> OKAY; write merges bytes per wstrb
//   prot[1] (security) and prot[2] (type) are ignored. EXOKAY is never returned.
//   wstrb=0 with OKAY: no bytes change, but reg_wr[index] still pulses.
//   reg_wr pulses in the cycle bvalid first rises; reg_q reflects new value that same cycle.
//   Read and write to the same register committing on the same edge: read returns the old value.
//   Read and write channels are fully independent; neither stalls the other.
// TESTING
//   1) wr 0x04 data 0xDEADBEEF strb 0xF prot 0 -> bresp OKAY, reg_q[63:32]=0xDEADBEEF,
//      reg_wr=8'h02 for 1 cycle; rd 0x04 -> rdata 0xDEADBEEF, rresp OKAY.
//   2) W (0x12345678, strb 0x3) 3 cycles before AW 0x00, reg0=0 -> reg0=0x00005678, OKAY.
//   3) NUM_REGS=8: wr/rd 0x40 -> bresp=rresp=DECERR, rdata=0, reg_q unchanged, reg_wr=0.
//   4) PRIV_MASK=8'h01: wr reg0 awprot=3'b000 -> SLVERR, unchanged; awprot=3'b001 -> OKAY.
//   5) bready low 5 cycles -> bvalid/bresp stable, awready=wready=0, new AW not accepted;
//      reads proceed with OKAY meanwhile.
//   6) areset pulsed while rvalid=1 -> rvalid=0 next cycle, reg_q=RESET_VALUE, arready=1 after.

Source files
------------

// File: rtl/axi4_lite_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_reg_slave
//  Description : AXI4-Lite responder exposing NUM_REGS 32-bit read/write
//                control registers. Terminates AW/W/B and AR/R.
//                Register contents are exported on reg_q, and reg_wr pulses
//                for one cycle for every register that a write updates.
//  Ports       : aclk/areset             clock, synchronous active-high reset
//                aw*/w*/b*               write address / data / response
//                ar*/r*                  read address / data
//                reg_q                   current register contents (reg i at
//                                        bits [32*i+31:32*i])
//                reg_wr                  per-register one-cycle write pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_reg_slave #(
    parameter int                     ADDR_W      = 8,
    parameter int                     NUM_REGS    = 8,
    parameter logic [NUM_REGS*32-1:0] RESET_VALUE = '0,
    parameter logic [NUM_REGS-1:0]    PRIV_MASK   = '0
) (
    input  logic                     aclk,
    input  logic                     areset,
    // write address
    input  logic [ADDR_W-1:0]        awaddr,
    input  logic [2:0]               awprot,
    input  logic                     awvalid,
    output logic                     awready,
    // write data
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    // write response
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    // read address
    input  logic [ADDR_W-1:0]        araddr,
    input  logic [2:0]               arprot,
    input  logic                     arvalid,
    output logic                     arready,
    // read data
    output logic [31:0]              rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    // register file view
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr
);

    localparam int         IDX_W       = ADDR_W - 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [0:0] WR_IDLE     = 1'b0;
    localparam logic [0:0] WR_RESP     = 1'b1;
    localparam logic [0:0] RD_IDLE     = 1'b0;
    localparam logic [0:0] RD_RESP     = 1'b1;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    logic [0:0]               wr_state_q, wr_state_d;
    logic [0:0]               rd_state_q, rd_state_d;

    logic                     aw_done_q;
    logic [IDX_W-1:0]         aw_idx_q;
    logic                     aw_priv_q;
    logic                     w_done_q;
    logic [31:0]              wdata_q;
    logic [3:0]               wstrb_q;

    logic [1:0]               bresp_q;
    logic [31:0]              rdata_q;
    logic [1:0]               rresp_q;
    logic [NUM_REGS*32-1:0]   regs_q;
    logic [NUM_REGS-1:0]      reg_wr_q;

    // ------------------------------------------------------------------
    // Write-side decode. An address or data beat captured earlier takes
    // precedence over the live bus, so the commit sees a consistent pair
    // whatever order AW and W arrived in.
    // ------------------------------------------------------------------
    logic                     w_aw_hs;
    logic                     w_w_hs;
    logic                     w_ar_hs;
    logic                     w_wr_go;
    logic [IDX_W-1:0]         w_wr_idx;
    logic [IDX_W-1:0]         w_rd_idx;
    logic                     w_wr_priv;
    logic [31:0]              w_wdata;
    logic [3:0]               w_wstrb;
    logic [NUM_REGS-1:0]      w_wr_hit;
    logic [NUM_REGS-1:0]      w_rd_hit;
    logic [1:0]               w_wr_resp;
    logic [1:0]               w_rd_resp;
    logic [31:0]              w_rd_word;

    // Security/type protection bits and the byte offset are not decoded.
    logic                     w_unused;
    assign w_unused = ^{awprot[2:1], arprot[2:1], awaddr[1:0], araddr[1:0]};

    assign w_aw_hs   = awvalid & awready;
    assign w_w_hs    = wvalid & wready;
    assign w_ar_hs   = arvalid & arready;

    assign w_wr_idx  = aw_done_q ? aw_idx_q  : awaddr[ADDR_W-1:2];
    assign w_wr_priv = aw_done_q ? aw_priv_q : awprot[0];
    assign w_wdata   = w_done_q  ? wdata_q   : wdata;
    assign w_wstrb   = w_done_q  ? wstrb_q   : wstrb;
    assign w_rd_idx  = araddr[ADDR_W-1:2];

    // Commit on the edge that completes the later of the two handshakes.
    assign w_wr_go   = (wr_state_q == WR_IDLE) & (aw_done_q | w_aw_hs) & (w_done_q | w_w_hs);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_dec
        assign w_wr_hit[i] = (w_wr_idx == IDX_W'(i));
        assign w_rd_hit[i] = (w_rd_idx == IDX_W'(i));
    end

    // No hit means the index lies beyond the register file.
    function automatic logic [1:0] decode_resp(input logic [NUM_REGS-1:0] hit,
                                               input logic                priv);
        if (hit == '0)
            return RESP_DECERR;
        else if (((hit & PRIV_MASK) != '0) && !priv)
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

    assign w_wr_resp = decode_resp(w_wr_hit, w_wr_priv);
    assign w_rd_resp = decode_resp(w_rd_hit, arprot[0]);

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_hit[i]) w_rd_word = regs_q[32*i +: 32];
        end
    end

    // ------------------------------------------------------------------
    // FSM state registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE: if (w_wr_go) wr_state_d = WR_RESP;
            WR_RESP: if (bready)  wr_state_d = WR_IDLE;
            default:              wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (w_ar_hs) rd_state_d = RD_RESP;
            RD_RESP: if (rready)  rd_state_d = RD_IDLE;
            default:              rd_state_d = RD_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs. Ready is forced low while reset is asserted so nothing
    // can be accepted in a cycle that is about to be discarded.
    // ------------------------------------------------------------------
    always_comb begin
        awready = !areset && (wr_state_q == WR_IDLE) && !aw_done_q;
        wready  = !areset && (wr_state_q == WR_IDLE) && !w_done_q;
        bvalid  = (wr_state_q == WR_RESP);
        arready = !areset && (rd_state_q == RD_IDLE);
        rvalid  = (rd_state_q == RD_RESP);
    end

    // ------------------------------------------------------------------
    // Write capture, register file and write response
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_done_q <= 1'b0;
            aw_idx_q  <= '0;
            aw_priv_q <= 1'b0;
            w_done_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            regs_q    <= RESET_VALUE;
            reg_wr_q  <= '0;
        end else begin
            reg_wr_q <= '0;
            if (w_wr_go) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                bresp_q   <= w_wr_resp;
                if (w_wr_resp == RESP_OKAY) begin
                    // Strobe pulses even when wstrb is zero.
                    reg_wr_q <= w_wr_hit;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        for (int k = 0; k < 4; k++) begin
                            if (w_wr_hit[i] && w_wstrb[k])
                                regs_q[32*i + 8*k +: 8] <= w_wdata[8*k +: 8];
                        end
                    end
                end
            end else begin
                if (w_aw_hs) begin
                    aw_done_q <= 1'b1;
                    aw_idx_q  <= awaddr[ADDR_W-1:2];
                    aw_priv_q <= awprot[0];
                end
                if (w_w_hs) begin
                    w_done_q <= 1'b1;
                    wdata_q  <= wdata;
                    wstrb_q  <= wstrb;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data path. regs_q is sampled before any same-edge write lands,
    // so a colliding read returns the old contents.
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (w_ar_hs) begin
            rresp_q <= w_rd_resp;
            rdata_q <= (w_rd_resp == RESP_OKAY) ? w_rd_word : 32'h0;
        end
    end

    assign bresp  = bresp_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign reg_q  = regs_q;
    assign reg_wr = reg_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_lite_reg_slave
//  Description : Directed vector bench for axi4_lite_reg_slave (8 registers,
//                reg0 privileged, non-zero reset contents in reg2 and reg7).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_reg_slave;

    localparam logic [1:0]   OKAY   = 2'b00;
    localparam logic [1:0]   SLVERR = 2'b10;
    localparam logic [1:0]   DECERR = 2'b11;
    localparam logic [255:0] RV = {32'hCAFE0007, 32'h0, 32'h0, 32'h0,
                                   32'h0, 32'h11112222, 32'h0, 32'h0};

    logic         aclk = 1'b0;
    logic         areset;
    logic [7:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [7:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [255:0] reg_q;
    logic [7:0]   reg_wr;

    axi4_lite_reg_slave #(
        .ADDR_W      (8),
        .NUM_REGS    (8),
        .RESET_VALUE (RV),
        .PRIV_MASK   (8'h01)
    ) dut (
        .aclk    (aclk),    .areset  (areset),
        .awaddr  (awaddr),  .awprot  (awprot),  .awvalid (awvalid), .awready (awready),
        .wdata   (wdata),   .wstrb   (wstrb),   .wvalid  (wvalid),  .wready  (wready),
        .bresp   (bresp),   .bvalid  (bvalid),  .bready  (bready),
        .araddr  (araddr),  .arprot  (arprot),  .arvalid (arvalid), .arready (arready),
        .rdata   (rdata),   .rresp   (rresp),   .rvalid  (rvalid),  .rready  (rready),
        .reg_q   (reg_q),   .reg_wr  (reg_wr)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        is_rd;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_wr;
    } vec_t;

    vec_t        vecs [17];
    logic [31:0] shadow [8];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pack_shadow();
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[32*i +: 32] = shadow[i];
        return p;
    endfunction

    task automatic reset_shadow();
        for (int i = 0; i < 8; i++) shadow[i] = RV[32*i +: 32];
    endtask

    // Entered and left just after a rising edge; AW and W offered together.
    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [2:0] p, output logic [1:0] resp,
                            output logic [7:0] wrp, output logic [255:0] regs, output logic ok);
        logic aw_hit, w_hit;
        awaddr = a; awprot = p; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
            @(negedge aclk);
            aw_hit = awvalid && awready;
            w_hit  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_hit) awvalid = 1'b0;
            if (w_hit)  wvalid  = 1'b0;
        end
        @(negedge aclk);
        ok   = !awvalid && !wvalid && bvalid;
        resp = bresp; wrp = reg_wr; regs = reg_q;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge aclk); #1;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [2:0] p,
                           output logic [31:0] d, output logic [1:0] r, output logic ok);
        logic hs;
        araddr = a; arprot = p; arvalid = 1'b1;
        for (int n = 0; n < 20 && arvalid; n++) begin
            @(negedge aclk);
            hs = arready;
            @(posedge aclk); #1;
            if (hs) arvalid = 1'b0;
        end
        @(negedge aclk);
        ok = !arvalid && rvalid;
        d  = rdata; r = rresp;
        arvalid = 1'b0;
        @(posedge aclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]   resp;
        logic [7:0]   wrp;
        logic [31:0]  rd;
        logic [255:0] regs;
        logic         ok;

        //             rd    addr   data          strb  prot  resp    rdata         wr
        vecs[0]  = '{1'b1, 8'h08, 32'h0,        4'h0, 3'd0, OKAY,   32'h11112222, 8'h00};
        vecs[1]  = '{1'b1, 8'h1C, 32'h0,        4'h0, 3'd0, OKAY,   32'hCAFE0007, 8'h00};
        vecs[2]  = '{1'b0, 8'h04, 32'hDEADBEEF, 4'hF, 3'd0, OKAY,   32'h0,        8'h02};
        vecs[3]  = '{1'b1, 8'h04, 32'h0,        4'h0, 3'd0, OKAY,   32'hDEADBEEF, 8'h00};
        vecs[4]  = '{1'b0, 8'h09, 32'hAABBCCDD, 4'hA, 3'd0, OKAY,   32'h0,        8'h04};
        vecs[5]  = '{1'b1, 8'h0B, 32'h0,        4'h0, 3'd0, OKAY,   32'hAA11CC22, 8'h00};
        vecs[6]  = '{1'b0, 8'h40, 32'h99999999, 4'hF, 3'd1, DECERR, 32'h0,        8'h00};
        vecs[7]  = '{1'b1, 8'h40, 32'h0,        4'h0, 3'd1, DECERR, 32'h0,        8'h00};
        vecs[8]  = '{1'b0, 8'h00, 32'hFFFFFFFF, 4'hF, 3'd0, SLVERR, 32'h0,        8'h00};
        vecs[9]  = '{1'b1, 8'h00, 32'h0,        4'h0, 3'd0, SLVERR, 32'h0,        8'h00};
        vecs[10] = '{1'b0, 8'h00, 32'h000000FF, 4'hF, 3'd1, OKAY,   32'h0,        8'h01};
        vecs[11] = '{1'b1, 8'h00, 32'h0,        4'h0, 3'd1, OKAY,   32'h000000FF, 8'h00};
        vecs[12] = '{1'b0, 8'h1C, 32'h12345678, 4'h0, 3'd0, OKAY,   32'h0,        8'h80};
        vecs[13] = '{1'b1, 8'h1C, 32'h0,        4'h0, 3'd6, OKAY,   32'hCAFE0007, 8'h00};
        vecs[14] = '{1'b1, 8'h20, 32'h0,        4'h0, 3'd1, DECERR, 32'h0,        8'h00};
        vecs[15] = '{1'b0, 8'h10, 32'h01020304, 4'h1, 3'd0, OKAY,   32'h0,        8'h10};
        vecs[16] = '{1'b1, 8'h10, 32'h0,        4'h0, 3'd0, OKAY,   32'h00000004, 8'h00};

        reset_shadow();
        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(posedge aclk);
        #1;
        @(negedge aclk);
        chk("rst_readies_low", {awready, wready, arready}, 3'b000);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("rst_reg_q",      reg_q, RV);
        chk("rst_valids",     {bvalid, rvalid}, 2'b00);
        chk("rst_resps",      {bresp, rresp}, 4'b0000);
        chk("rst_rdata",      rdata, 32'h0);
        chk("rst_reg_wr",     reg_wr, 8'h00);
        chk("rst_readies_hi", {awready, wready, arready}, 3'b111);
        @(posedge aclk); #1;

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < $size(vecs); v++) begin
            if (vecs[v].is_rd) begin
                do_read(vecs[v].addr, vecs[v].prot, rd, resp, ok);
                chk($sformatf("v%0d_rd_done", v),  ok, 1'b1);
                chk($sformatf("v%0d_rresp", v),    resp, vecs[v].exp_resp);
                chk($sformatf("v%0d_rdata", v),    rd, vecs[v].exp_rdata);
            end else begin
                if (vecs[v].exp_resp == OKAY) begin
                    for (int k = 0; k < 4; k++)
                        if (vecs[v].strb[k])
                            shadow[vecs[v].addr[4:2]][8*k +: 8] = vecs[v].data[8*k +: 8];
                end
                do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].prot,
                         resp, wrp, regs, ok);
                chk($sformatf("v%0d_wr_done", v),  ok, 1'b1);
                chk($sformatf("v%0d_bresp", v),    resp, vecs[v].exp_resp);
                chk($sformatf("v%0d_reg_wr", v),   wrp, vecs[v].exp_wr);
                chk($sformatf("v%0d_reg_q", v),    regs, pack_shadow());
            end
        end
        @(negedge aclk);
        chk("reg_wr_one_cycle", reg_wr, 8'h00);
        @(posedge aclk); #1;

        // ---------------- W three cycles ahead of AW ----------------
        wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1'b1;
        @(negedge aclk);
        chk("wfirst_wready", wready, 1'b1);
        @(posedge aclk); #1;
        wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            chk($sformatf("wfirst_hold%0d", k), {wready, awready, bvalid}, 3'b010);
            @(posedge aclk); #1;
        end
        awaddr = 8'h00; awprot = 3'd1; awvalid = 1'b1;
        @(negedge aclk);
        chk("wfirst_awready", awready, 1'b1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        @(negedge aclk);
        shadow[0] = 32'h00005678;
        chk("wfirst_bvalid", bvalid, 1'b1);
        chk("wfirst_bresp",  bresp, OKAY);
        chk("wfirst_reg0",   reg_q[31:0], 32'h00005678);
        chk("wfirst_reg_wr", reg_wr, 8'h01);
        @(posedge aclk); #1;

        // ---------------- B back-pressure, reads carry on ----------------
        bready = 1'b0;
        awaddr = 8'h0C; awprot = 3'd0; wdata = 32'h00000033; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        chk("bp_first_accept", {awready, wready}, 2'b11);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        shadow[3] = 32'h00000033;
        awaddr = 8'h14; wdata = 32'h00000055; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h04; arprot = 3'd0; arvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk($sformatf("bp_hold%0d", k), {bvalid, bresp, awready, wready}, 5'b10000);
            if (k == 0) chk("bp_reg3", reg_q[127:96], 32'h00000033);
            if (k == 1) chk("bp_read", {rvalid, rresp, rdata}, {1'b1, OKAY, 32'hDEADBEEF});
            @(posedge aclk); #1;
            if (k == 0) arvalid = 1'b0;
        end
        bready = 1'b1;
        @(negedge aclk);
        chk("bp_release_bvalid", bvalid, 1'b1);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("bp_second_accept", {awready, wready}, 2'b11);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        shadow[5] = 32'h00000055;
        @(negedge aclk);
        chk("bp_second_resp", {bvalid, bresp}, {1'b1, OKAY});
        chk("bp_second_wr",   reg_wr, 8'h20);
        chk("bp_second_regq", reg_q, pack_shadow());
        @(posedge aclk); #1;

        // ---------------- reset while R is pending ----------------
        rready = 1'b0;
        araddr = 8'h04; arprot = 3'd0; arvalid = 1'b1;
        @(negedge aclk);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        @(negedge aclk);
        chk("rrst_rvalid_before", rvalid, 1'b1);
        @(posedge aclk); #1;
        areset = 1'b1;
        @(negedge aclk);
        chk("rrst_readies_low", {awready, wready, arready}, 3'b000);
        @(posedge aclk); #1;
        areset = 1'b0; rready = 1'b1;
        reset_shadow();
        @(negedge aclk);
        chk("rrst_rvalid_after", {rvalid, bvalid}, 2'b00);
        chk("rrst_reg_q",        reg_q, RV);
        chk("rrst_arready",      arready, 1'b1);
        @(posedge aclk); #1;
        do_read(8'h04, 3'd0, rd, resp, ok);
        chk("rrst_readback", {ok, resp, rd}, {1'b1, OKAY, 32'h0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
